// File: rtl/io_pkg.sv
// Shared constants, IRQ FSM state encoding and priority helper for the input stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_pkg;

  localparam int NPORTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DROP = 2'd2
  } irq_state_e;

  // Index of the lowest set bit; port 0 has the highest priority.
  function automatic logic [1:0] lowest_idx(input logic [NPORTS-1:0] v);
    lowest_idx = 2'd0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[1:0];
    end
  endfunction

endpackage

// File: rtl/port_debounce.sv
// Synchronises one asynchronous port, debounces it and holds the accepted value.
// Latency: SYNC_STAGES + STABLE_CYCLES cycles from a clean input step to val_out.
// Backpressure: none; upd_out is a single-cycle strobe, combinational with the accepting edge.
module port_debounce #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ext_in,
  output logic [WIDTH-1:0] val_out,
  output logic             upd_out
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] s;
  logic             upd;

  assign s       = sync_q[SYNC_STAGES-1];
  assign val_out = val_q;
  assign upd_out = upd;

  // Synchroniser chain: pure flop-to-flop wiring, no logic between stages.
  always_comb begin
    sync_d[0] = ext_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Candidate tracking: a new value must be seen STABLE_CYCLES times in a row before acceptance.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    val_d  = val_q;
    upd    = 1'b0;
    if (s == val_q) begin
      cnt_d = '0;
    end else if (s != cand_q) begin
      cand_d = s;
      if (STABLE_CYCLES == 1) begin
        val_d = s;
        cnt_d = '0;
        upd   = 1'b1;
      end else begin
        cnt_d = CW'(1);
      end
    end else begin
      if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        val_d = cand_q;
        cnt_d = '0;
        upd   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers, all cleared while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      val_q  <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
    end
  end

endmodule

// File: rtl/io_input_stage.sv
// Four debounced input ports feeding the cpu, with a prioritised req/ack change interrupt.
// Latency: 5 cycles ext step -> cpu_pN at defaults; irq rises the cycle after pending is visible.
// Backpressure: irq/irq_vec held until irq_ack; no new request while irq_ack stays high.
module io_input_stage
  import io_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ext_p0,
  input  logic [WIDTH-1:0] ext_p1,
  input  logic [WIDTH-1:0] ext_p2,
  input  logic [WIDTH-1:0] ext_p3,
  output logic [WIDTH-1:0] cpu_p0,
  output logic [WIDTH-1:0] cpu_p1,
  output logic [WIDTH-1:0] cpu_p2,
  output logic [WIDTH-1:0] cpu_p3,
  input  logic [3:0]       irq_mask,
  output logic             irq,
  output logic [1:0]       irq_vec,
  input  logic             irq_ack,
  output logic [3:0]       pending
);

  logic [WIDTH-1:0]  ext_arr [NPORTS];
  logic [WIDTH-1:0]  val_arr [NPORTS];
  logic [NPORTS-1:0] upd;

  irq_state_e        state_q, state_d;
  logic              irq_q, irq_d;
  logic [1:0]        vec_q, vec_d;
  logic [NPORTS-1:0] pending_q, pending_d;
  logic [NPORTS-1:0] req_bits;

  assign ext_arr[0] = ext_p0;
  assign ext_arr[1] = ext_p1;
  assign ext_arr[2] = ext_p2;
  assign ext_arr[3] = ext_p3;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    port_debounce #(
      .WIDTH        (WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .ext_in (ext_arr[g]),
      .val_out(val_arr[g]),
      .upd_out(upd[g])
    );
  end

  assign cpu_p0  = val_arr[0];
  assign cpu_p1  = val_arr[1];
  assign cpu_p2  = val_arr[2];
  assign cpu_p3  = val_arr[3];
  assign irq     = irq_q;
  assign irq_vec = vec_q;
  assign pending = pending_q;

  assign req_bits = pending_q & irq_mask;

  // IRQ FSM and pending flags; a port update always wins over an ack clearing the same flag.
  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    vec_d     = vec_q;
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_bits) begin
          vec_d   = lowest_idx(req_bits);
          irq_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          pending_d[vec_q] = 1'b0;
          irq_d            = 1'b0;
          state_d          = ST_WAIT_DROP;
        end
      end
      ST_WAIT_DROP: begin
        // Once ack drops, arbitrate directly so back-to-back requests see one idle cycle.
        if (!irq_ack) begin
          if (|req_bits) begin
            vec_d   = lowest_idx(req_bits);
            irq_d   = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    pending_d = pending_d | upd;
  end

  // FSM, request and pending registers; reset drops irq at once with no replay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      vec_q     <= 2'd0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_io_input_stage.sv
// Bench for io_input_stage: scoreboard of expected cpu port updates plus directed IRQ checks.
// Latency: expects each clean port change on cpu_pN exactly 5 cycles after it is driven.
// Backpressure: exercises the irq_ack handshake, masking and ack/update collisions.
module tb_io_input_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ext_p0, ext_p1, ext_p2, ext_p3;
  logic [7:0] cpu_p0, cpu_p1, cpu_p2, cpu_p3;
  logic [3:0] irq_mask;
  logic       irq;
  logic [1:0] irq_vec;
  logic       irq_ack;
  logic [3:0] pending;

  typedef struct {
    int         port;
    logic [7:0] val;
    int         cyc;
  } upd_t;

  upd_t       sb_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  logic [7:0] last [4];

  io_input_stage dut (
    .clk     (clk),
    .reset   (reset),
    .ext_p0  (ext_p0),
    .ext_p1  (ext_p1),
    .ext_p2  (ext_p2),
    .ext_p3  (ext_p3),
    .cpu_p0  (cpu_p0),
    .cpu_p1  (cpu_p1),
    .cpu_p2  (cpu_p2),
    .cpu_p3  (cpu_p3),
    .irq_mask(irq_mask),
    .irq     (irq),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack),
    .pending (pending)
  );

  initial forever #30 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
  endtask

  task automatic expect_upd(input int port, input logic [7:0] val);
    upd_t e;
    e.port = port;
    e.val  = val;
    e.cyc  = cyc + 5;
    sb_q.push_back(e);
  endtask

  task automatic wait_nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int k = 0;
    while (!irq && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(irq), 32'h1);
  endtask

  task automatic service(input string tag, input logic [3:0] exp_pend);
    irq_ack = 1'b1;
    wait_nclk(1);
    chk({tag, "_irq_drop"}, 32'(irq), 32'h0);
    chk({tag, "_pending"}, 32'(pending), 32'(exp_pend));
    irq_ack = 1'b0;
    wait_nclk(1);
  endtask

  // Scoreboard monitor: every change of a cpu port must match the oldest expected update.
  always @(negedge clk) begin : mon
    logic [7:0] cur [4];
    upd_t       e;
    cur = '{cpu_p0, cpu_p1, cpu_p2, cpu_p3};
    for (int i = 0; i < 4; i++) begin
      if (!reset) begin
        last[i] = cur[i];
      end else if (cur[i] !== last[i]) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("unexp_upd_p%0d", i), 32'(cur[i]), 32'(last[i]));
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("sb_port_p%0d", i), 32'(i), 32'(e.port));
          chk($sformatf("sb_val_p%0d", i), 32'(cur[i]), 32'(e.val));
          chk($sformatf("sb_cyc_p%0d", i), 32'(cyc), 32'(e.cyc));
        end
        last[i] = cur[i];
      end
    end
  end

  initial begin
    reset    = 1'b0;
    ext_p0   = 8'h08;
    ext_p1   = 8'h00;
    ext_p2   = 8'h00;
    ext_p3   = 8'h00;
    irq_mask = 4'b0000;
    irq_ack  = 1'b0;
    for (int i = 0; i < 4; i++) last[i] = 8'h00;

    // Reset state and first accepted value after release.
    wait_nclk(1);
    chk("rst_cpu_p0", 32'(cpu_p0), 32'h0);
    chk("rst_cpu_p1", 32'(cpu_p1), 32'h0);
    chk("rst_cpu_p2", 32'(cpu_p2), 32'h0);
    chk("rst_cpu_p3", 32'(cpu_p3), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_irq_vec", 32'(irq_vec), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    wait_nclk(1);
    reset = 1'b1;
    expect_upd(0, 8'h08);
    wait_nclk(4);
    chk("t1_not_early", 32'(cpu_p0), 32'h0);
    wait_nclk(1);
    chk("t1_cpu_p0", 32'(cpu_p0), 32'h08);
    chk("t1_pending", 32'(pending), 32'h1);

    // Masked pending raises no irq until the mask opens.
    wait_nclk(3);
    chk("t4_irq_masked", 32'(irq), 32'h0);
    chk("t4_pending_kept", 32'(pending), 32'h1);
    irq_mask = 4'b0001;
    wait_nclk(1);
    chk("t4_irq", 32'(irq), 32'h1);
    chk("t4_vec", 32'(irq_vec), 32'h0);
    service("t4", 4'b0000);

    // Bring port 1 to 8'h04 and service it, then glitch it.
    ext_p1   = 8'h04;
    expect_upd(1, 8'h04);
    irq_mask = 4'b0010;
    wait_nclk(6);
    chk("t2_irq", 32'(irq), 32'h1);
    chk("t2_vec", 32'(irq_vec), 32'h1);
    service("t2", 4'b0000);
    ext_p1 = 8'hFF;
    wait_nclk(2);
    ext_p1 = 8'h04;
    wait_nclk(8);
    chk("t2_glitch_cpu_p1", 32'(cpu_p1), 32'h04);
    chk("t2_glitch_pending", 32'(pending), 32'h0);
    chk("t2_glitch_irq", 32'(irq), 32'h0);

    // Simultaneous changes on ports 2 and 3: priority, hold, ack-high blocking.
    irq_mask = 4'b1111;
    ext_p2   = 8'h55;
    ext_p3   = 8'hAA;
    expect_upd(2, 8'h55);
    expect_upd(3, 8'hAA);
    wait_nclk(5);
    chk("t3_pending_both", 32'(pending), 32'hC);
    chk("t3_irq_not_yet", 32'(irq), 32'h0);
    wait_nclk(1);
    chk("t3_irq", 32'(irq), 32'h1);
    chk("t3_vec2", 32'(irq_vec), 32'h2);
    irq_mask = 4'b0000;
    wait_nclk(1);
    chk("t3_hold_irq", 32'(irq), 32'h1);
    chk("t3_hold_vec", 32'(irq_vec), 32'h2);
    irq_mask = 4'b1111;
    irq_ack  = 1'b1;
    wait_nclk(1);
    chk("t3_ack_irq", 32'(irq), 32'h0);
    chk("t3_ack_pending", 32'(pending), 32'h8);
    wait_nclk(1);
    chk("t3_ack_high_blocks", 32'(irq), 32'h0);
    irq_ack = 1'b0;
    wait_nclk(1);
    chk("t3_irq_again", 32'(irq), 32'h1);
    chk("t3_vec3", 32'(irq_vec), 32'h3);
    service("t3", 4'b0000);

    // Port 0 update on the same edge as the ack of vector 0: set wins.
    irq_mask = 4'b0001;
    ext_p0   = 8'h10;
    expect_upd(0, 8'h10);
    wait_nclk(6);
    chk("t5_irq", 32'(irq), 32'h1);
    chk("t5_vec", 32'(irq_vec), 32'h0);
    ext_p0 = 8'h20;
    expect_upd(0, 8'h20);
    wait_nclk(4);
    irq_ack = 1'b1;
    wait_nclk(1);
    chk("t5_ack_irq", 32'(irq), 32'h0);
    chk("t5_set_wins", 32'(pending), 32'h1);
    chk("t5_cpu_p0", 32'(cpu_p0), 32'h20);
    irq_ack = 1'b0;
    wait_irq("t5_second_irq", 4);
    chk("t5_second_vec", 32'(irq_vec), 32'h0);

    // Asynchronous reset while a request is outstanding.
    @(posedge clk);
    #10;
    reset = 1'b0;
    #1;
    chk("t6_irq_async", 32'(irq), 32'h0);
    chk("t6_pending", 32'(pending), 32'h0);
    chk("t6_cpu_p0", 32'(cpu_p0), 32'h0);
    ext_p0 = 8'h00;
    ext_p1 = 8'h00;
    ext_p2 = 8'h00;
    ext_p3 = 8'h00;
    wait_nclk(3);
    reset = 1'b1;
    wait_nclk(8);
    chk("t6_no_replay_irq", 32'(irq), 32'h0);
    chk("t6_no_replay_pending", 32'(pending), 32'h0);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
